// File: rtl/branch_off_enc.sv
// Branch offset encoder: turns a pc/target pair into the word-offset
// immediate that the branch sign-extend/shift-by-2 path will decode back
// into target - (pc + 4). Two-stage valid/ready pipeline with range and
// alignment flags plus a saturating count of flagged results.
module branch_off_enc #(
    parameter int DEPTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      pc,
    input  logic [31:0]      target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEPTH-3:0] imm,
    output logic             misalign,
    output logic             overflow,
    output logic [15:0]      err_cnt
);

    // Offset does not fit in signed DEPTH bits when the bits above the
    // sign position are not a pure sign extension.
    function automatic logic range_err_f(input logic [31:0] d);
        logic [31-DEPTH+1:0] hi_s;
        hi_s = d[31:DEPTH-1];
        range_err_f = !((&hi_s) || !(|hi_s));
    endfunction

    logic              s1_valid_r;
    logic [31:0]       diff_r;
    logic              s2_valid_r;
    logic [DEPTH-3:0]  imm_r;
    logic              misalign_r;
    logic              overflow_r;
    logic [15:0]       err_cnt_r;

    logic              s1_adv_s;
    logic              s2_adv_s;
    logic              out_xfer_s;
    logic              in_ready_s;

    // Pipeline advance decisions; in_ready follows out_ready combinationally
    // so a full pipeline keeps streaming without a bubble.
    always_comb begin
        s2_adv_s   = 1'b0;
        s1_adv_s   = 1'b0;
        out_xfer_s = 1'b0;
        in_ready_s = 1'b0;
        out_xfer_s = s2_valid_r && out_ready;
        s2_adv_s   = !s2_valid_r || out_ready;
        s1_adv_s   = !s1_valid_r || s2_adv_s;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = s1_adv_s;
        end
    end

    // Stage 1: capture the 32-bit modulo byte offset relative to pc + 4.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            diff_r     <= 32'd0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                diff_r <= target - pc - 32'd4;
            end
        end
    end

    // Stage 2: encode the immediate and flags; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            imm_r      <= '0;
            misalign_r <= 1'b0;
            overflow_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                imm_r      <= diff_r[DEPTH-1:2];
                misalign_r <= (diff_r[1:0] != 2'b00);
                overflow_r <= range_err_f(diff_r);
            end
        end
    end

    // Count delivered results carrying any error flag, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 16'd0;
        end else if (out_xfer_s && (misalign_r || overflow_r) &&
                     (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign imm       = imm_r;
    assign misalign  = misalign_r;
    assign overflow  = overflow_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_branch_off_enc.sv
// Directed bench for branch_off_enc (DEPTH=18): table of single transfers,
// then streaming, back-pressure and mid-flight reset sequences.
module tb_branch_off_enc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm;
    logic        misalign;
    logic        overflow;
    logic [15:0] err_cnt;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic [15:0] imm;
        logic        mis;
        logic        ovf;
    } vec_t;

    vec_t vecs [11];

    branch_off_enc #(.DEPTH(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc        (pc),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .misalign  (misalign),
        .overflow  (overflow),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_err;
        logic [15:0] bp_exp [3];
        int          idx;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        pc       = 32'd0;
        target   = 32'd0;

        vecs[0]  = '{32'h0040_0000, 32'h0040_0010, 16'h0003, 1'b0, 1'b0};
        vecs[1]  = '{32'h0040_0010, 32'h0040_0000, 16'hFFFB, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_0000, 32'h0002_0000, 16'h7FFF, 1'b0, 1'b0};
        vecs[3]  = '{32'h0000_0000, 32'hFFFE_0004, 16'h8000, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0000, 32'h0002_0004, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{32'h0040_0000, 32'h0040_0006, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFFF_FFF0, 32'h0000_0010, 16'h0007, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'hFFFE_0000, 16'h7FFF, 1'b0, 1'b1};
        vecs[8]  = '{32'h0000_0000, 32'h0010_0007, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{32'h0000_1000, 32'h0000_1004, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{32'h0000_1000, 32'h0000_1001, 16'hFFFF, 1'b1, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_imm", {16'd0, imm}, 32'd0);
        chk("reset_flags", {30'd0, misalign, overflow}, 32'd0);
        chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // table-driven single transfers
        exp_err = 16'd0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            pc       = vecs[i].pc;
            target   = vecs[i].target;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            pc       = 32'hDEAD_BEEF;
            target   = 32'h1234_5677;
            @(negedge clk);
            chk($sformatf("v%0d_lat1", i), {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_imm", i), {16'd0, imm}, {16'd0, vecs[i].imm});
            chk($sformatf("v%0d_mis", i), {31'd0, misalign}, {31'd0, vecs[i].mis});
            chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
            if (vecs[i].mis || vecs[i].ovf) exp_err = exp_err + 16'd1;
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("v%0d_err_cnt", i), {16'd0, err_cnt}, {16'd0, exp_err});
        end

        // full-throughput stream: imm = k for diff = 4k
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                in_valid = 1'b1;
                pc       = 32'h0000_0100;
                target   = 32'h0000_0104 + 32'(4 * k);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k < 4) chk($sformatf("stream%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            if (k >= 2) begin
                chk($sformatf("stream%0d_valid", k), {31'd0, out_valid}, 32'd1);
                chk($sformatf("stream%0d_imm", k), {16'd0, imm}, 32'(k - 2));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // back-pressure: three pairs offered with the consumer stalled
        bp_exp[0] = 16'd1;
        bp_exp[1] = 16'd2;
        bp_exp[2] = 16'd3;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            pc       = 32'd0;
            target   = 32'(8 + 4 * k);
            #1;
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, (k < 2) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_imm", k), {16'd0, imm}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) begin
                if (idx < 3) chk($sformatf("bp_out%0d_imm", idx), {16'd0, imm}, {16'd0, bp_exp[idx]});
                idx++;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
        end
        chk("bp_out_count", 32'(idx), 32'd3);
        chk("bp_err_cnt", {16'd0, err_cnt}, {16'd0, exp_err});

        // reset with both stages occupied
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            pc       = 32'd0;
            target   = 32'h0000_0006;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pc        = 32'd0;
        target    = 32'h0000_0014;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_lat1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_imm", {16'd0, imm}, 32'd4);
        @(negedge clk);
        chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        chk("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
